seven_seg_scan: RTL and testbench

Output-side human interface block: drives a multiplexed, common-cathode style seven-segment display from a packed hex value, so register contents (bus, output register, PC) become visible to the operator. It is the counterpart of the switch-conditioning front end: switches are filtered on the way in, display data is scanned out here. It runs from the same slow clock as the front end, takes a tear-free snapshot once per frame, and inserts a blanking gap between digits to prevent ghosting.

---
 rtl/seven_seg_scan_if.sv | 23 ++
 rtl/seven_seg_scan.sv | 149 ++++++++++++++
 tb/tb_seven_seg_scan.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_if.sv
// Display bus: operator inputs (enable, packed hex value, decimal points,
// leading-zero control) and the registered segment/digit drive outputs.
interface seven_seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  enable;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic                  blank_leading;
  logic [6:0]            segments;
  logic                  dp_out;
  logic [DIGITS-1:0]     digit_sel;

  modport master (
    output enable, value, dp, blank_leading,
    input  segments, dp_out, digit_sel
  );

  modport slave (
    input  enable, value, dp, blank_leading,
    output segments, dp_out, digit_sel
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: snapshots the display data once per
// frame, then shows each digit for SCAN_COUNT-1 cycles after one blank cycle.
module seven_seg_scan #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_COUNT = 4
) (
  input  logic            clock,
  input  logic            reset,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // IDLE: stopped after reset/disable; the next enabled edge starts a frame.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VAL_W-1:0]   val_q, val_d;
  logic [DIGITS-1:0]  dp_q, dp_d;
  logic               bl_q, bl_d;
  logic [6:0]         seg_q, seg_d;
  logic               dpo_q, dpo_d;
  logic [DIGITS-1:0]  sel_q, sel_d;
  logic               capture;
  logic [3:0]         nib;
  logic               hi_zero;

  // Hex to segment pattern, bit0=a .. bit6=g.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next slot/digit, frame snapshot and next registered display outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    dp_d    = dp_q;
    bl_d    = bl_q;
    seg_d   = '0;
    dpo_d   = 1'b0;
    sel_d   = '0;
    capture = 1'b0;
    nib     = '0;
    hi_zero = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          idx_d   = '0;
          capture = 1'b1;
        end
        default: begin
          if (cnt_q == CNT_W'(SCAN_COUNT - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
              idx_d   = '0;
              capture = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase

      state_d = (cnt_d == '0) ? ST_BLANK : ST_SHOW;

      if (capture) begin
        val_d = bus.value;
        dp_d  = bus.dp;
        bl_d  = bus.blank_leading;
      end

      // Digit drive only in SHOW; leading zeros darken segments but keep the digit slot.
      if (state_d == ST_SHOW) begin
        nib          = val_d[32'(idx_d) * 4 +: 4];
        hi_zero      = ((val_d >> (32'(idx_d) * 4)) == '0);
        sel_d[idx_d] = 1'b1;
        dpo_d        = dp_d[idx_d];
        seg_d        = (bl_d && (idx_d != '0) && hi_zero) ? 7'h00 : decode(nib);
      end
    end
  end

  // State, snapshot and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      bl_q    <= 1'b0;
      seg_q   <= '0;
      dpo_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      bl_q    <= bl_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.segments  = seg_q;
  assign bus.dp_out    = dpo_q;
  assign bus.digit_sel = sel_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a frame-position reference model
// pushes the expected display per edge, a negedge monitor pops and compares.
module tb_seven_seg_scan;

  localparam int unsigned D  = 4;
  localparam int unsigned SC = 4;

  typedef struct {
    logic [6:0]   seg;
    logic         dp;
    logic [D-1:0] sel;
  } exp_t;

  logic clk;
  logic rst;
  seven_seg_scan_if #(.DIGITS(D)) bus ();

  seven_seg_scan #(.DIGITS(D), .SCAN_COUNT(SC)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: running frame position and frame snapshot.
  bit              m_started = 1'b0;
  int              m_pos     = 0;
  logic [4*D-1:0]  m_val     = '0;
  logic [D-1:0]    m_dp      = '0;
  bit              m_bl      = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict the outputs after the coming edge from the current inputs, then clock.
  task automatic step();
    exp_t e;
    int   dig;
    int   slot;
    e.seg = '0;
    e.dp  = 1'b0;
    e.sel = '0;
    if (rst || !bus.enable) begin
      m_started = 1'b0;
      if (rst) begin
        m_val = '0;
        m_dp  = '0;
        m_bl  = 1'b0;
      end
    end else begin
      if (!m_started) begin
        m_started = 1'b1;
        m_pos     = 0;
      end else begin
        m_pos = (m_pos + 1) % (D * SC);
      end
      if (m_pos == 0) begin
        m_val = bus.value;
        m_dp  = bus.dp;
        m_bl  = bus.blank_leading;
      end
      dig  = m_pos / SC;
      slot = m_pos % SC;
      if (slot != 0) begin
        e.sel = D'(1) << dig;
        e.dp  = m_dp[dig];
        if (m_bl && dig >= 1 && (m_val / (1 << (4 * dig))) == 0)
          e.seg = 7'h00;
        else
          e.seg = seg_tab[(m_val >> (4 * dig)) & 'hF];
      end
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare each presented output against the scoreboard, plus digit_sel invariants.
  logic [D-1:0] prev_sel = '0;
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.segments !== e.seg || bus.dp_out !== e.dp || bus.digit_sel !== e.sel) begin
        failures++;
        $display("FAIL display t=%0t got seg=%02h dp=%0b sel=%b expected seg=%02h dp=%0b sel=%b",
                 $time, bus.segments, bus.dp_out, bus.digit_sel, e.seg, e.dp, e.sel);
      end
      checks++;
      if (!$onehot0(bus.digit_sel) ||
          (prev_sel != '0 && bus.digit_sel != '0 && bus.digit_sel != prev_sel)) begin
        failures++;
        $display("FAIL sel_invariant t=%0t got sel=%b after %b expected one-hot with blank between digits",
                 $time, bus.digit_sel, prev_sel);
      end
      prev_sel = bus.digit_sel;
    end
  end

  initial begin
    rst               = 1'b1;
    bus.enable        = 1'b0;
    bus.value         = '0;
    bus.dp            = '0;
    bus.blank_leading = 1'b0;
    run(2);

    // Basic scan of 1234 over two frames.
    rst        = 1'b0;
    bus.value  = 16'h1234;
    bus.enable = 1'b1;
    run(20);

    // Mid-frame change at edge 8 only appears next frame.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    bus.value = 16'h1234;
    run(7);
    bus.value = 16'hABCD;
    run(30);

    // Leading-zero blanking with a decimal point on a suppressed digit.
    bus.value         = 16'h0050;
    bus.dp            = 4'b0100;
    bus.blank_leading = 1'b1;
    run(32);
    bus.value = 16'h0000;
    bus.dp    = 4'b0000;
    run(32);

    // Every nibble in digit 0.
    bus.blank_leading = 1'b0;
    for (int n = 0; n < 16; n++) begin
      bus.value = 16'(n);
      run(D * SC);
    end

    // Enable dropped at edge 7 for three edges.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    bus.value = 16'h5A3C;
    run(6);
    bus.enable = 1'b0;
    run(3);
    bus.enable = 1'b1;
    run(20);

    // Reset at edge 11 for one edge.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(10);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(20);

    // Randomized inputs, occasional disable and reset.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) bus.value = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) bus.dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.blank_leading = 1'($urandom);
      bus.enable = ($urandom_range(0, 24) != 0);
      rst        = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;
    bus.enable = 1'b1;
    run(4);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
